mem_stream_reader: RTL
======================

// Module: mem_stream_reader
// PURPOSE
//  Read-side initiator for the SRAM memory wrapper. On a start command it issues
//  LEN sequential reads from BASE and absorbs the wrapper's fixed 1-cycle read
//  latency. Returned words go out as a valid/ready stream with backpressure.
//  It sits between a control/DMA engine and the wrapper's rd_* port. The wr_* port is never driven.
// PARAMETERS
//  DATA_W      8           word width; equals the wrapper's DATA_W
//  ADDR_W      8           address width; equals the wrapper's ADDR_W
//  LEN_W       ADDR_W+1    width of transfer length (max 2^ADDR_W words)
//  FIFO_DEPTH  4           response buffer depth in words; power of 2, >=2
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous active-low reset
//  start_i        in   1       1-cycle command pulse; sampled only in IDLE
//  base_addr_i    in   ADDR_W  first word address; sampled with start_i
//  len_i          in   LEN_W   number of words; sampled with start_i
//  busy_o         out  1       high from accepted start until done_o
//  done_o         out  1       1-cycle pulse when the transfer completes
//  mem_rd_addr_o  out  ADDR_W  read address to the memory wrapper
//  mem_rd_vld_o   out  1       read request, 1 word per cycle when high
//  mem_rd_data_i  in   DATA_W  read data from the wrapper
//  mem_rd_rdy_i   in   1       read data valid, exactly 1 cycle after mem_rd_vld_o
//  m_data_o       out  DATA_W  stream data
//  m_vld_o        out  1       stream valid
//  m_last_o       out  1       high with the final word of the transfer
//  m_rdy_i        in   1       stream ready from the consumer
// BEHAVIOUR
//  Reset: all outputs 0. FSM goes to IDLE. FIFO is emptied. Counters and credits clear.
//  Reset mid-transfer aborts the transfer: no done_o pulse and no further requests.
//  FSM states: IDLE, ISSUE, DRAIN.
//   IDLE: start_i with len_i!=0 latches base and length, then goes to ISSUE (busy_o=1).
//         start_i with len_i==0 pulses done_o the next cycle, issues no reads, and stays in IDLE.
//   ISSUE: assert mem_rd_vld_o when remaining>0 and credit>0.
//         credit = FIFO_DEPTH - fifo_count - inflight (inflight is 0 or 1).
//         Each issued read increments the address and decrements remaining.
//         Go to DRAIN in the cycle the last read is issued.
//   DRAIN: leave when inflight==0, the FIFO is empty, and the last word has handshaked.
//         On exit pulse done_o, drop busy_o in the same cycle, and return to IDLE.
//  start_i while busy_o=1 is ignored.
//  Address arithmetic is modulo 2^ADDR_W: a transfer past the top wraps to address 0.
//  Response path: a cycle with mem_rd_rdy_i=1 writes mem_rd_data_i into the FIFO unconditionally.
//   The credit scheme guarantees space. mem_rd_rdy_i with inflight==0 is ignored and nothing is written.
//  Stream: m_data_o/m_vld_o come from the FIFO head, registered.
//   A word becomes visible the cycle after it is written.
//   A handshake occurs when m_vld_o & m_rdy_i. m_data_o stays stable while m_vld_o & !m_rdy_i.
//   m_last_o=1 exactly on the word whose index is len-1.
//  Latency: start_i at cycle T -> mem_rd_vld_o at T+1 -> mem_rd_rdy_i at T+2 -> m_vld_o at T+3.
//  Throughput: with m_rdy_i held high, 1 word/cycle sustained and no bubbles after the first.
//  Backpressure: with m_rdy_i low, at most FIFO_DEPTH words are requested.
//   Requests resume the cycle after credit returns.
//  Simultaneous FIFO write and read when full or empty are legal. Count is unchanged when both occur.
// TESTING
//  1. base=0x10, len=4, m_rdy_i=1 -> reads 0x10..0x13 on T+1..T+4; m_vld_o T+3..T+6;
//     m_last_o on word 4; done_o at T+7.
//  2. len=0 -> done_o at T+1; mem_rd_vld_o never asserts; busy_o stays 0.
//  3. base=0xFE, len=4 (ADDR_W=8) -> read addresses 0xFE,0xFF,0x00,0x01; data in order.
//  4. len=10, m_rdy_i=0 -> exactly 4 reads issued, then mem_rd_vld_o low. Raise m_rdy_i ->
//     all 10 words in order, no loss or duplication.
//  5. start_i pulsed again mid-transfer with a different base -> ignored; original stream completes.
//  6. rst_n low during ISSUE with FIFO partly full -> all outputs 0 immediately.
//     After release: no m_vld_o and no done_o until a new start.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Read-side initiator for the SRAM wrapper: issues LEN sequential reads from BASE
// and streams the returned words out over valid/ready with a credit-limited FIFO.
module mem_stream_reader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = ADDR_W + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    output logic              mem_rd_vld_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    input  logic              mem_rd_rdy_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_vld_o,
    output logic              m_last_o,
    input  logic              m_rdy_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshakes: a memory read is issued in every cycle mem_rd_vld_o is high and its
    // data returns with mem_rd_rdy_i exactly one cycle later; a stream word transfers
    // in every cycle m_vld_o & m_rdy_i, and m_data_o holds while m_vld_o & !m_rdy_i.
    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  sent_cnt;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              wr_en;
    logic              rd_en;
    logic [CW-1:0]     count_nxt;
    logic [LEN_W-1:0]  rem_nxt;
    logic [OW-1:0]     occ_nxt;
    logic              can_issue;
    logic              last_hs;

    assign wr_en    = mem_rd_rdy_i & inflight;
    assign rd_en    = m_vld_o & m_rdy_i;
    assign m_vld_o  = (count != '0);
    assign m_data_o = m_vld_o ? fifo_mem[rd_ptr] : '0;
    assign m_last_o = m_vld_o & (sent_cnt == len_q - LEN_W'(1));
    assign last_hs  = rd_en & m_last_o;

    // The request for the next cycle is decided here so mem_rd_vld_o can be a flop;
    // a word reserved by the read issued this cycle is counted as inflight next cycle.
    always_comb begin
        count_nxt = count;
        rem_nxt   = remaining;
        occ_nxt   = '0;
        can_issue = 1'b0;
        if (wr_en && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_nxt = count - CW'(1);
        end
        if (mem_rd_vld_o) begin
            rem_nxt = remaining - LEN_W'(1);
        end
        occ_nxt   = {1'b0, count_nxt} + OW'(mem_rd_vld_o);
        can_issue = (rem_nxt != '0) && (occ_nxt < OW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            mem_rd_addr_o <= '0;
            mem_rd_vld_o  <= 1'b0;
            len_q         <= '0;
            remaining     <= '0;
            sent_cnt      <= '0;
            inflight      <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= mem_rd_vld_o;
            if (rd_en) begin
                sent_cnt <= sent_cnt + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    mem_rd_vld_o <= 1'b0;
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            busy_o        <= 1'b1;
                            mem_rd_addr_o <= base_addr_i;
                            mem_rd_vld_o  <= 1'b1;
                            len_q         <= len_i;
                            remaining     <= len_i;
                            sent_cnt      <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_rd_vld_o) begin
                        mem_rd_addr_o <= mem_rd_addr_o + ADDR_W'(1);
                        remaining     <= rem_nxt;
                    end
                    mem_rd_vld_o <= can_issue;
                    if (rem_nxt == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mem_rd_vld_o <= 1'b0;
                    if (last_hs && !inflight && count == CW'(1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy_o       <= 1'b0;
                    mem_rd_vld_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
        end
    end

    // Storage needs no reset: m_data_o is gated by the reset-cleared count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= mem_rd_data_i;
        end
    end

endmodule
